// File: rtl/timer_pkg.sv
// Shared types and defaults for the stopwatch counter and its helpers.
package timer_pkg;

    // Width of the value handed to binary_to_BCD.
    localparam int unsigned COUNT_W = 8;

    // Defaults: one tick per second at 50 MHz, display range 0..99.
    localparam int unsigned DEF_TICK_DIV    = 50000000;
    localparam int unsigned DEF_MAX_COUNT   = 99;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2
    } state_e;

    // Next seconds value: wraps to 0 after max_val and never goes past it.
    function automatic logic [COUNT_W-1:0] next_value(
        input logic [COUNT_W-1:0] value,
        input logic [COUNT_W-1:0] max_val
    );
        logic [COUNT_W-1:0] nxt;
        nxt = '0;
        if (value < max_val) begin
            nxt = value + COUNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: multi-flop synchroniser followed by a registered
// rising-edge detector. A held button yields exactly one 1-cycle pulse.
module btn_sync_edge
    import timer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;

    // Synchroniser chain, previous-level flop and registered edge pulse.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Controllable seconds counter for the digital timer: start/stop, lap freeze
// and clear from raw buttons, with an internal prescaler generating the tick.
module stopwatch_counter
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned MAX_COUNT   = DEF_MAX_COUNT,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    input  logic               btn_start_stop,
    input  logic               btn_lap,
    input  logic               btn_clear,
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic               lap_active,
    output logic               wrap
);

    localparam int unsigned        PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] MAX_VAL    = COUNT_W'(MAX_COUNT);

    logic sp;
    logic lp;
    logic cp;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [COUNT_W-1:0] value_q, value_d;
    logic [COUNT_W-1:0] lap_q, lap_d;
    logic               lap_active_q, lap_active_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               wrap_q, wrap_d;

    logic               lap_toggle;
    logic               clear;
    logic               tick;

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_start_stop (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .btn       (btn_start_stop),
        .pulse     (sp)
    );

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_lap (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .btn       (btn_lap),
        .pulse     (lp)
    );

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_clear (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .btn       (btn_clear),
        .pulse     (cp)
    );

    // Control FSM: pulse priority is clear > start/stop > lap among the
    // pulses that the current state acts on.
    always_comb begin
        state_d    = state_q;
        lap_toggle = 1'b0;
        clear      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sp) begin
                    state_d = StRunning;
                end
            end
            StRunning: begin
                // Clear is not honoured while running, so it never masks sp.
                if (sp) begin
                    state_d = StPaused;
                end else if (lp) begin
                    lap_toggle = 1'b1;
                end
            end
            StPaused: begin
                if (cp) begin
                    state_d = StIdle;
                    clear   = 1'b1;
                end else if (sp) begin
                    state_d = StRunning;
                end else if (lp) begin
                    lap_toggle = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Prescaler: advances only while running; a pause landing on the due
    // tick holds it at the last phase so the tick fires right after resume.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (state_q == StIdle || clear) begin
            presc_d = '0;
        end else if (state_q == StRunning) begin
            if (presc_q == PRESC_LAST) begin
                if (!sp) begin
                    tick    = 1'b1;
                    presc_d = '0;
                end
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Internal seconds value and wrap pulse.
    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        if (clear) begin
            value_d = '0;
        end else if (tick) begin
            value_d = next_value(value_q, MAX_VAL);
            wrap_d  = (value_q >= MAX_VAL);
        end
    end

    // Lap freeze: capture the live value on the rising toggle and show the
    // captured value for as long as lap_active is set.
    always_comb begin
        lap_d        = lap_q;
        lap_active_d = lap_active_q ^ lap_toggle;
        if (lap_toggle && !lap_active_q) begin
            lap_d = value_q;
        end
        if (clear) begin
            lap_active_d = 1'b0;
        end
        count_d = lap_active_q ? lap_q : value_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            value_q      <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            count_q      <= '0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            value_q      <= value_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            count_q      <= count_d;
            wrap_q       <= wrap_d;
        end
    end

    assign count      = count_q;
    assign running    = (state_q == StRunning);
    assign lap_active = lap_active_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus random button activity,
// all checked every cycle against a seconds/phase model of the stopwatch.
module tb_stopwatch_counter;

    localparam int unsigned TD = 4;
    localparam int unsigned MC = 99;
    localparam int unsigned SS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bs = 1'b0;
    logic       bl = 1'b0;
    logic       bc = 1'b0;
    logic [7:0] count;
    logic       running;
    logic       lap_active;
    logic       wrap;

    int n_cmp = 0;
    int n_fail = 0;
    int wrap_seen = 0;
    int max_seen = 0;

    stopwatch_counter #(
        .TICK_DIV    (TD),
        .MAX_COUNT   (MC),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_50MHz      (clk),
        .reset          (reset),
        .btn_start_stop (bs),
        .btn_lap        (bl),
        .btn_clear      (bc),
        .count          (count),
        .running        (running),
        .lap_active     (lap_active),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 running, 2 paused; secs is the live seconds value,
    // phase the elapsed clocks inside the current second.
    typedef struct {
        int mode;
        int secs;
        int phase;
        bit lapped;
        int lapval;
        int shown;
        bit wrap;
    } model_t;

    model_t m = '{default: 0};

    // Raw button samples from previous edges, bit 0 the most recent.
    logic [SS+1:0] hs = '0;
    logic [SS+1:0] hl = '0;
    logic [SS+1:0] hc = '0;

    function automatic model_t step(input model_t c, input bit sp, input bit lp, input bit cp);
        model_t n;
        bit     tick;
        bit     toggle;
        n       = c;
        n.wrap  = 1'b0;
        n.shown = c.lapped ? c.lapval : c.secs;
        tick    = 1'b0;
        toggle  = 1'b0;
        case (c.mode)
            0: if (sp) n.mode = 1;
            1: begin
                if (sp) begin
                    n.mode = 2;
                    if (c.phase < TD - 1) n.phase = c.phase + 1;
                end else begin
                    if (c.phase == TD - 1) begin
                        n.phase = 0;
                        tick    = 1'b1;
                    end else begin
                        n.phase = c.phase + 1;
                    end
                    if (lp) toggle = 1'b1;
                end
            end
            default: begin
                if (cp) begin
                    n.mode   = 0;
                    n.secs   = 0;
                    n.phase  = 0;
                    n.lapped = 1'b0;
                end else if (sp) begin
                    n.mode = 1;
                end else if (lp) begin
                    toggle = 1'b1;
                end
            end
        endcase
        if (tick) begin
            n.wrap = (c.secs == MC);
            n.secs = (c.secs + 1) % (MC + 1);
        end
        if (toggle) begin
            n.lapped = !c.lapped;
            if (!c.lapped) n.lapval = c.secs;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m  <= '{default: 0};
            hs <= '0;
            hl <= '0;
            hc <= '0;
        end else begin
            m  <= step(m, hs[SS] & ~hs[SS+1], hl[SS] & ~hl[SS+1], hc[SS] & ~hc[SS+1]);
            hs <= {hs[SS:0], bs};
            hl <= {hl[SS:0], bl};
            hc <= {hc[SS:0], bc};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_secs(input int target, input int budget);
        int i = 0;
        while (m.secs != target && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (m.secs != target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_secs: secs %0d, required %0d", m.secs, target);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("count", int'(count), m.shown);
            chk("running", int'(running), int'(m.mode == 1));
            chk("lap_active", int'(lap_active), int'(m.lapped));
            chk("wrap", int'(wrap), int'(m.wrap));
            if (wrap) wrap_seen++;
            if (int'(count) > max_seen) max_seen = int'(count);
        end
    end

    initial begin
        cycles(3);
        chk("rst_count", int'(count), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_lap", int'(lap_active), 0);
        chk("rst_wrap", int'(wrap), 0);
        reset = 1'b0;
        cycles(2);
        chk("idle_running", int'(running), 0);

        // Start: running appears on the 4th edge after the press.
        bs = 1'b1;
        cycles(3);
        chk("start_lat3", int'(running), 0);
        cycles(1);
        chk("start_lat4", int'(running), 1);
        cycles(4);
        bs = 1'b0;

        // Lap at 5: the toggle lands on the edge that also ticks 5 -> 6.
        wait_secs(5, 200);
        bl = 1'b1;
        cycles(6);
        bl = 1'b0;
        chk("lap_on", int'(lap_active), 1);
        wait_secs(9, 200);
        chk("lap_frozen", int'(count), 5);
        bl = 1'b1;
        cycles(6);
        bl = 1'b0;
        chk("lap_off", int'(lap_active), 0);

        // Wrap 99 -> 0 exactly once, never showing 100.
        wait_secs(99, 1000);
        wait_secs(0, 20);
        cycles(3);
        chk("wrap_pulses", wrap_seen, 1);
        chk("max_seen", max_seen, 99);

        // Pause, hold, resume, pause, clear.
        bs = 1'b1;
        cycles(5);
        bs = 1'b0;
        chk("paused", int'(running), 0);
        cycles(50);
        bs = 1'b1;
        cycles(5);
        bs = 1'b0;
        chk("resumed", int'(running), 1);
        cycles(10);
        bs = 1'b1;
        cycles(5);
        bs = 1'b0;
        cycles(3);
        bc = 1'b1;
        cycles(5);
        bc = 1'b0;
        cycles(3);
        chk("clr_running", int'(running), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_lap", int'(lap_active), 0);

        // Start, pause, then start/stop and clear together: clear wins.
        bs = 1'b1;
        cycles(5);
        bs = 1'b0;
        cycles(12);
        bs = 1'b1;
        cycles(5);
        bs = 1'b0;
        cycles(5);
        bs = 1'b1;
        bc = 1'b1;
        cycles(6);
        bs = 1'b0;
        bc = 1'b0;
        cycles(3);
        chk("both_running", int'(running), 0);
        chk("both_count", int'(count), 0);

        // Clear while running is ignored.
        bs = 1'b1;
        cycles(5);
        bs = 1'b0;
        cycles(20);
        bc = 1'b1;
        cycles(5);
        bc = 1'b0;
        cycles(5);
        chk("clr_in_run", int'(running), 1);

        // Reset mid-run at 37 with lap active: outputs clear before any edge.
        wait_secs(35, 1000);
        bl = 1'b1;
        cycles(5);
        bl = 1'b0;
        wait_secs(37, 100);
        chk("lap_before_rst", int'(lap_active), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_running", int'(running), 0);
        chk("async_lap", int'(lap_active), 0);
        chk("async_wrap", int'(wrap), 0);

        // Button held through reset release gives exactly one start pulse.
        bs = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(30);
        chk("held_once", int'(running), 1);
        bs = 1'b0;
        cycles(5);

        // Random button activity with occasional mid-cycle resets.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) bs = ~bs;
            if ($urandom_range(0, 15) == 0) bl = ~bl;
            if ($urandom_range(0, 23) == 0) bc = ~bc;
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
